// File: rtl/binary_to_bcd_digits.sv
`default_nettype none
// ============================================================================
// Module  : binary_to_bcd_digits
// Brief   : Sequential 16-bit binary to 5-digit BCD converter (double dabble,
//           one bit per clock) with optional leading-zero blanking for a
//           seven-segment display decoder.
// Revision: 1.0 - initial release
// ============================================================================
module binary_to_bcd_digits #(
   parameter bit         BLANK_LEADING_ZEROS = 1'b1,
   parameter logic [3:0] BLANK_CODE          = 4'hF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] value,
   output logic        busy,
   output logic        done,
   output logic [19:0] digits
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int unsigned c_NUM_DIGITS = 5;
   localparam int unsigned c_BIN_W      = 16;
   localparam int unsigned c_BCD_W      = 4 * c_NUM_DIGITS;
   localparam logic [4:0]  c_LAST_ITER  = 5'(c_BIN_W - 1);

   // A blanked display reads "0": upper four digits blank, ones digit zero.
   localparam logic [19:0] c_DIGITS_RESET =
      BLANK_LEADING_ZEROS ? {{4{BLANK_CODE}}, 4'h0} : 20'h00000;

   // -------------------------------------------------------------------------
   // State machine encoding
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_FORMAT  = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic [c_BIN_W-1:0]  bin_q,    bin_d;
   logic [c_BCD_W-1:0]  bcd_q,    bcd_d;
   logic [4:0]          iter_q,   iter_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;
   logic [c_BCD_W-1:0]  digits_q, digits_d;

   // Accumulator after the per-nibble add-3 correction of this iteration.
   logic [c_BCD_W-1:0]  w_bcd_adj;
   // w_lead_zero[k]: digit k and every digit above it are zero.
   logic [c_NUM_DIGITS-1:0] w_lead_zero;
   // Accumulator with leading-zero blanking applied, ready for the display.
   logic [c_BCD_W-1:0]  w_fmt;

   // -------------------------------------------------------------------------
   // Add-3 correction: a nibble >= 5 would reach >= 10 after doubling, so it
   // is pre-biased by 3 to carry into the next decade on the shift. The
   // nibble is at most 9 here, so the 4-bit add never overflows.
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < c_NUM_DIGITS; gi++) begin : g_add3
      logic [3:0] w_nib;
      assign w_nib = bcd_q[gi*4 +: 4];
      assign w_bcd_adj[gi*4 +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
   end

   // -------------------------------------------------------------------------
   // Leading-zero detection and blanking. Each flag looks directly at all the
   // bits from its own digit upward, so no ripple chain is needed. The ones
   // digit is always shown so a zero value still displays "0"; interior zeros
   // are never blanked because a non-zero higher digit clears the flag.
   // -------------------------------------------------------------------------
   for (genvar gk = 0; gk < c_NUM_DIGITS; gk++) begin : g_blank
      assign w_lead_zero[gk] = ~|bcd_q[c_BCD_W-1 : gk*4];

      if (gk == 0) begin : g_ones
         assign w_fmt[3:0] = bcd_q[3:0];
      end else if (BLANK_LEADING_ZEROS) begin : g_blankable
         assign w_fmt[gk*4 +: 4] = w_lead_zero[gk] ? BLANK_CODE : bcd_q[gk*4 +: 4];
      end else begin : g_shown
         assign w_fmt[gk*4 +: 4] = bcd_q[gk*4 +: 4];
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath control; every target defaults to hold.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      iter_d   = iter_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      digits_d = digits_q;

      case (state_q)
         S_IDLE: begin
            // start is only honoured here, so requests while busy are dropped.
            if (start) begin
               bin_d   = value;
               bcd_d   = '0;
               iter_d  = '0;
               busy_d  = 1'b1;
               state_d = S_CONVERT;
            end
         end

         S_CONVERT: begin
            // Shift {BCD, binary} left one bit; the binary MSB enters the BCD LSB.
            {bcd_d, bin_d} = {w_bcd_adj[c_BCD_W-2:0], bin_q, 1'b0};
            iter_d         = iter_q + 5'd1;
            if (iter_q == c_LAST_ITER) begin
               state_d = S_FORMAT;
            end
         end

         S_FORMAT: begin
            // Display digits update only here, never with partial results.
            digits_d = w_fmt;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         iter_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         digits_q <= c_DIGITS_RESET;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         iter_q   <= iter_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         digits_q <= digits_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign digits = digits_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_digits.sv
`default_nettype none
// ============================================================================
// Module  : tb_binary_to_bcd_digits
// Brief   : Self-checking bench for binary_to_bcd_digits. Two instances share
//           the stimulus: one with leading-zero blanking, one without.
// Revision: 1.0 - initial release
// ============================================================================
module tb_binary_to_bcd_digits;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] value;
   logic        busy,    busy_nb;
   logic        done,    done_nb;
   logic [19:0] digits,  digits_nb;

   int vectors     = 0;
   int miscompares = 0;

   binary_to_bcd_digits #(.BLANK_LEADING_ZEROS(1'b1), .BLANK_CODE(4'hF)) dut (
      .clock (clock), .reset (reset), .start (start), .value (value),
      .busy  (busy),  .done  (done),  .digits (digits)
   );

   binary_to_bcd_digits #(.BLANK_LEADING_ZEROS(1'b0), .BLANK_CODE(4'hF)) dut_nb (
      .clock (clock),   .reset (reset),   .start (start), .value (value),
      .busy  (busy_nb), .done  (done_nb), .digits (digits_nb)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] val;
      logic [19:0] exp;
      logic [19:0] exp_nb;
   } vec_t;

   // Reference: plain decimal split, then blank leading zeros above the ones.
   function automatic logic [19:0] ref_digits(input int unsigned v, input bit blank);
      int unsigned d [5];
      logic [19:0] r;
      bit lead;
      r    = '0;
      lead = 1'b1;
      for (int k = 0; k < 5; k++) begin
         d[k] = v % 10;
         v    = v / 10;
      end
      for (int k = 4; k >= 0; k--) begin
         if (blank && lead && d[k] == 0 && k != 0) r[k*4 +: 4] = 4'hF;
         else begin
            r[k*4 +: 4] = 4'(d[k]);
            lead = 1'b0;
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait (bounded) for done; busy must stay high and digits must hold meanwhile.
   // value is scrambled every cycle to show it has no effect after acceptance.
   task automatic wait_done(input int bound, output int n);
      logic [19:0] prev, prev_nb;
      int busy_bad, hold_bad;
      prev = digits; prev_nb = digits_nb;
      busy_bad = 0; hold_bad = 0; n = 0;
      while (done !== 1'b1 && n < bound) begin
         if (busy !== 1'b1 || busy_nb !== 1'b1) busy_bad++;
         if (digits !== prev || digits_nb !== prev_nb) hold_bad++;
         @(posedge clock); #1;
         n++;
         value = 16'($urandom);
      end
      check("done_seen", 32'(done), 32'd1);
      check("done_nb_seen", 32'(done_nb), 32'd1);
      check("busy_during_conv", busy_bad, 0);
      check("digits_hold", hold_bad, 0);
      check("busy_low_at_done", 32'(busy), 32'd0);
   endtask

   // Pulse start with v and wait for done; returns positioned in the done cycle.
   task automatic run_conv(input logic [15:0] v);
      int n;
      start = 1'b1;
      value = v;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(40, n);
      check("latency", n, 17);
   endtask

   vec_t tbl [8];

   initial begin
      int n;
      int done_cnt;
      logic [15:0] v;
      logic [19:0] held;

      tbl[0] = '{16'd0,     20'hFFFF0, 20'h00000};
      tbl[1] = '{16'd12345, 20'h12345, 20'h12345};
      tbl[2] = '{16'd65535, 20'h65535, 20'h65535};
      tbl[3] = '{16'd7,     20'hFFFF7, 20'h00007};
      tbl[4] = '{16'd105,   20'hFF105, 20'h00105};
      tbl[5] = '{16'd10000, 20'h10000, 20'h10000};
      tbl[6] = '{16'd42,    20'hFFF42, 20'h00042};
      tbl[7] = '{16'd1009,  20'hF1009, 20'h01009};

      // Reset state
      reset = 1'b1; start = 1'b0; value = 16'd0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_digits", 32'(digits), 32'h000FFFF0);
      check("rst_digits_nb", 32'(digits_nb), 32'h00000000);
      reset = 1'b0;
      @(posedge clock); #1;

      // Table: back-to-back, each start raised in the previous done cycle
      for (int i = 0; i < 8; i++) begin
         run_conv(tbl[i].val);
         check($sformatf("tbl%0d_digits", i), 32'(digits), 32'(tbl[i].exp));
         check($sformatf("tbl%0d_digits_nb", i), 32'(digits_nb), 32'(tbl[i].exp_nb));
      end
      start = 1'b0;
      @(posedge clock); #1;
      check("done_single_pulse", 32'(done), 32'd0);

      // start while busy is ignored: 500 accepted, 9 pulsed at E5
      start = 1'b1; value = 16'd500;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      start = 1'b1; value = 16'd9;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(40, n);
      check("busy_ign_latency", n, 12);
      check("busy_ign_digits", 32'(digits), 32'h000FF500);
      // Start in the done cycle is accepted
      run_conv(16'd9);
      check("b2b_digits", 32'(digits), 32'h000FFFF9);
      start = 1'b0;
      @(posedge clock); #1;

      // Asynchronous reset at E8 of a 65535 conversion
      start = 1'b1; value = 16'd65535;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (7) begin @(posedge clock); #1; end
      @(posedge clock); #3;
      reset = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_digits", 32'(digits), 32'h000FFFF0);
      check("midrst_digits_nb", 32'(digits_nb), 32'h00000000);
      @(posedge clock); #1;
      reset = 1'b0;
      done_cnt = 0;
      repeat (20) begin
         @(posedge clock); #1;
         if (done === 1'b1) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 0);
      run_conv(16'd321);
      check("post_rst_digits", 32'(digits), 32'h000FF321);
      start = 1'b0;
      @(posedge clock); #1;

      // Random regression against the decimal reference
      for (int i = 0; i < 1000; i++) begin
         case (i % 50)
            0:       v = 16'd0;
            1:       v = 16'd65535;
            2:       v = 16'd9999;
            default: v = 16'($urandom_range(0, 65535));
         endcase
         run_conv(v);
         check("rnd_digits", 32'(digits), 32'(ref_digits(v, 1'b1)));
         check("rnd_digits_nb", 32'(digits_nb), 32'(ref_digits(v, 1'b0)));
         held = digits;
         @(posedge clock); #1;
         check("rnd_done_once", 32'(done), 32'd0);
         check("rnd_digits_stable", 32'(digits), 32'(held));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
